// File: rtl/ethernet_tx_read_sequencer_pkg.sv
// Shared Ethernet width helpers.
// Used by the TX/RX datapath blocks to derive beat and pointer widths.
package ethernet_tx_read_sequencer_pkg;

  localparam int eth_data_width_default = 32;
  localparam int eth_mtu_default = 2048;

  function automatic int eth_bytes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int eth_addr_width(input int mtu);
    return $clog2(mtu);
  endfunction

  function automatic int eth_size_width(input int mtu);
    return $clog2(mtu + 1);
  endfunction

  function automatic int eth_ptr_width(input int data_width, input int mtu);
    return $clog2(mtu / (data_width / 8));
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Wrapping up-counter with synchronous clear.
// Clear together with up loads one.
module bsg_counter_clear_up #(
  parameter int max_val_p = 511,
  parameter int width_p = 9
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i && up_i)
      count_d = width_p'(1);
    else if (clear_i)
      count_d = '0;
    else if (up_i)
      count_d = (count_q == width_p'(max_val_p)) ? '0 : count_q + width_p'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous reset to zero.
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_reset_set_clear.sv
// Per-bit set/clear register; set has priority.
module bsg_dff_reset_set_clear #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] set_i,
  input  logic [width_p-1:0] clear_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    data_d = (data_q & ~clear_i) | set_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/ethernet_tx_read_sequencer_tkeep.sv
// Byte-valid mask for a TX beat.
// Only the last beat of a packet can be partial.
module eth_tkeep_decode #(
  parameter int bytes_p = 4,
  parameter int lg_bytes_p = 2
) (
  input  logic                  last_i,
  input  logic [lg_bytes_p-1:0] rsize_lo_i,
  output logic [bytes_p-1:0]    tkeep_o
);

  always_comb begin
    tkeep_o = '1;
    if (last_i && (rsize_lo_i != '0))
      tkeep_o = (bytes_p'(1) << rsize_lo_i) - bytes_p'(1);
  end

endmodule

// File: rtl/ethernet_tx_read_sequencer.sv
// TX read sequencer: walks the packet buffer and feeds AXI-Stream.
// Sideband is registered to align with the one-cycle RAM latency.
module ethernet_tx_read_sequencer
  import ethernet_tx_read_sequencer_pkg::*;
#(
  parameter int data_width_p = eth_data_width_default,
  parameter int eth_mtu_p = eth_mtu_default,
  localparam int bytes_lp = eth_bytes(data_width_p),
  localparam int addr_width_lp = eth_addr_width(eth_mtu_p),
  localparam int size_width_lp = eth_size_width(eth_mtu_p),
  localparam int ptr_width_lp = eth_ptr_width(data_width_p, eth_mtu_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     packet_avail_i,
  input  logic [size_width_lp-1:0] packet_rsize_i,
  input  logic [data_width_p-1:0]  packet_rdata_i,
  output logic                     packet_rvalid_o,
  output logic [addr_width_lp-1:0] packet_raddr_o,
  output logic                     packet_ack_o,
  output logic                     send_complete_o,
  output logic [data_width_p-1:0]  tx_axis_tdata_o,
  output logic [bytes_lp-1:0]      tx_axis_tkeep_o,
  output logic                     tx_axis_tvalid_o,
  output logic                     tx_axis_tlast_o,
  output logic                     tx_axis_tuser_o,
  input  logic                     tx_axis_tready_i
);

  localparam int lg_bytes_lp = $clog2(bytes_lp);
  localparam int ptr_max_lp = (eth_mtu_p / bytes_lp) - 1;

  if (!(data_width_p == 32 || data_width_p == 64)) begin : g_bad_width
    $error("data_width_p must be 32 or 64");
  end

  logic [ptr_width_lp-1:0]  ptr_q;
  logic [ptr_width_lp-1:0]  ptr_end;
  logic [size_width_lp-1:0] rsize_m1;
  logic [bytes_lp-1:0]      tkeep_d;
  logic [bytes_lp+1:0]      side_d, side_q;
  logic                     tvalid_q;
  logic                     sending, issue, last;

  assign sending  = ~(tvalid_q & ~tx_axis_tready_i);
  assign issue    = packet_avail_i & sending;
  // size 0 underflows to all ones, i.e. the maximum pointer
  assign rsize_m1 = packet_rsize_i - size_width_lp'(1);
  assign ptr_end  = ptr_width_lp'(rsize_m1 >> lg_bytes_lp);
  assign last     = (ptr_q == ptr_end);

  assign packet_rvalid_o = issue;
  assign packet_raddr_o  = {ptr_q, {lg_bytes_lp{1'b0}}};
  assign packet_ack_o    = issue & last;
  assign send_complete_o = issue & last;

  bsg_counter_clear_up #(
    .max_val_p(ptr_max_lp),
    .width_p  (ptr_width_lp)
  ) u_ptr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(issue & last),
    .up_i   (issue & ~last),
    .count_o(ptr_q)
  );

  eth_tkeep_decode #(
    .bytes_p   (bytes_lp),
    .lg_bytes_p(lg_bytes_lp)
  ) u_tkeep (
    .last_i    (last),
    .rsize_lo_i(packet_rsize_i[lg_bytes_lp-1:0]),
    .tkeep_o   (tkeep_d)
  );

  assign side_d = {tkeep_d, last, 1'b0};

  bsg_dff_reset_en #(
    .width_p(bytes_lp + 2)
  ) u_side (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (issue),
    .data_i (side_d),
    .data_o (side_q)
  );

  bsg_dff_reset_set_clear #(
    .width_p(1)
  ) u_tvalid (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .set_i  (issue),
    .clear_i(tx_axis_tready_i),
    .data_o (tvalid_q)
  );

  assign tx_axis_tdata_o  = packet_rdata_i;
  assign tx_axis_tvalid_o = tvalid_q;
  assign tx_axis_tkeep_o  = side_q[bytes_lp+1:2];
  assign tx_axis_tlast_o  = side_q[1];
  assign tx_axis_tuser_o  = side_q[0];

endmodule

// File: tb/tb_ethernet_tx_read_sequencer.sv
// Randomized bench for the TX read sequencer, 32- and 64-bit builds.
// A packet-level model predicts reads, acks and AXI-Stream beats.
module tb_ethernet_tx_read_sequencer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        sel;
  logic        avail;
  logic        tready;
  logic [11:0] rsize;
  logic [63:0] rdata;

  always #5 clk = ~clk;

  logic        avail32, avail64;
  logic        rvalid32, ack32, sc32, tvalid32, tlast32, tuser32;
  logic [10:0] raddr32;
  logic [31:0] tdata32;
  logic [3:0]  tkeep32;
  logic        rvalid64, ack64, sc64, tvalid64, tlast64, tuser64;
  logic [10:0] raddr64;
  logic [63:0] tdata64;
  logic [7:0]  tkeep64;

  assign avail32 = avail & ~sel;
  assign avail64 = avail & sel;

  ethernet_tx_read_sequencer #(.data_width_p(32), .eth_mtu_p(2048)) u_dut32 (
    .clk_i(clk), .reset_i(reset_i),
    .packet_avail_i(avail32), .packet_rsize_i(rsize),
    .packet_rdata_i(rdata[31:0]),
    .packet_rvalid_o(rvalid32), .packet_raddr_o(raddr32),
    .packet_ack_o(ack32), .send_complete_o(sc32),
    .tx_axis_tdata_o(tdata32), .tx_axis_tkeep_o(tkeep32),
    .tx_axis_tvalid_o(tvalid32), .tx_axis_tlast_o(tlast32),
    .tx_axis_tuser_o(tuser32), .tx_axis_tready_i(tready)
  );

  ethernet_tx_read_sequencer #(.data_width_p(64), .eth_mtu_p(2048)) u_dut64 (
    .clk_i(clk), .reset_i(reset_i),
    .packet_avail_i(avail64), .packet_rsize_i(rsize),
    .packet_rdata_i(rdata),
    .packet_rvalid_o(rvalid64), .packet_raddr_o(raddr64),
    .packet_ack_o(ack64), .send_complete_o(sc64),
    .tx_axis_tdata_o(tdata64), .tx_axis_tkeep_o(tkeep64),
    .tx_axis_tvalid_o(tvalid64), .tx_axis_tlast_o(tlast64),
    .tx_axis_tuser_o(tuser64), .tx_axis_tready_i(tready)
  );

  logic        rvalid_m, ack_m, sc_m, tvalid_m, tlast_m, tuser_m;
  logic [10:0] raddr_m;
  logic [63:0] tdata_m;
  logic [7:0]  tkeep_m;

  always_comb begin
    rvalid_m = sel ? rvalid64 : rvalid32;
    raddr_m  = sel ? raddr64  : raddr32;
    ack_m    = sel ? ack64    : ack32;
    sc_m     = sel ? sc64     : sc32;
    tvalid_m = sel ? tvalid64 : tvalid32;
    tlast_m  = sel ? tlast64  : tlast32;
    tuser_m  = sel ? tuser64  : tuser32;
    tdata_m  = sel ? tdata64  : {32'h0, tdata32};
    tkeep_m  = sel ? tkeep64  : {4'h0, tkeep32};
  end

  int pid;

  function automatic logic [63:0] pat(input int p, input logic [10:0] a);
    return {16'(p) ^ 16'h5a5a, 5'd3, a, 16'(p), 5'd0, a};
  endfunction

  // synchronous-read packet buffer stand-in
  always_ff @(posedge clk)
    if (rvalid_m) rdata <= pat(pid, raddr_m);

  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          sizes_q[$];
  logic [63:0] exp_d[$];
  logic [7:0]  exp_k[$];
  bit          exp_l[$];
  bit          loaded, exp_tv;
  int          cur_size, cur_n, idx;
  int          tready_pct, gap_pct;
  int          n_ack, n_done;

  function automatic int bytes_now();
    return sel ? 8 : 4;
  endfunction

  task automatic push_beats();
    int b, rem;
    logic [63:0] d;
    logic [7:0]  k;
    b = bytes_now();
    rem = cur_size % b;
    for (int i = 0; i < cur_n; i++) begin
      d = pat(pid, 11'(i * b));
      if (b == 4) d[63:32] = '0;
      k = (b == 8) ? 8'hff : 8'h0f;
      if (i == cur_n - 1 && rem != 0) k = 8'((1 << rem) - 1);
      exp_d.push_back(d);
      exp_k.push_back(k);
      exp_l.push_back(i == cur_n - 1);
    end
  endtask

  task automatic load_packet();
    int b;
    b = bytes_now();
    cur_size = sizes_q.pop_front();
    pid++;
    cur_n = (cur_size == 0) ? 2048 / b : (cur_size + b - 1) / b;
    idx = 0;
    loaded = 1'b1;
    push_beats();
  endtask

  task automatic step();
    int  b;
    bit  issue;
    b = bytes_now();
    @(negedge clk);
    reset_i = 1'b0;
    chk("tvalid", 64'(tvalid_m), 64'(exp_tv));
    if (exp_tv) begin
      if (exp_d.size() == 0) chk("beat_queue", 64'd0, 64'd1);
      else begin
        chk("tdata", tdata_m, exp_d[0]);
        chk("tkeep", 64'(tkeep_m), 64'(exp_k[0]));
        chk("tlast", 64'(tlast_m), 64'(exp_l[0]));
        chk("tuser", 64'(tuser_m), 64'd0);
      end
    end
    if (!loaded && sizes_q.size() > 0 && $urandom_range(99) >= gap_pct)
      load_packet();
    avail = loaded;
    rsize = 12'(cur_size);
    tready = ($urandom_range(99) < tready_pct);
    issue = loaded && !(exp_tv && !tready);
    #1;
    chk("rvalid", 64'(rvalid_m), 64'(issue));
    if (issue) begin
      chk("raddr", 64'(raddr_m), 64'(idx * b));
      chk("ack", 64'(ack_m), 64'(idx == cur_n - 1));
      chk("send_complete", 64'(sc_m), 64'(idx == cur_n - 1));
    end else begin
      chk("ack_idle", 64'(ack_m), 64'd0);
    end
    if (ack_m) n_ack++;
    if (exp_tv && tready && exp_d.size() > 0) begin
      void'(exp_d.pop_front());
      void'(exp_k.pop_front());
      void'(exp_l.pop_front());
    end
    exp_tv = issue | (exp_tv & ~tready);
    if (issue) begin
      if (idx == cur_n - 1) begin
        loaded = 1'b0;
        idx = 0;
        n_done++;
      end else idx++;
    end
  endtask

  task automatic run(input int budget);
    int c;
    c = 0;
    while ((loaded || sizes_q.size() > 0 || exp_tv) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic set_sel(input logic v);
    @(posedge clk);
    #1;
    sel = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    avail = 1'b0;
    tready = 1'b1;
    @(posedge clk);
    #1;
    exp_tv = 1'b0;
    idx = 0;
    exp_d.delete();
    exp_k.delete();
    exp_l.delete();
    if (loaded) push_beats();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tvalid"}, 64'(tvalid_m), 64'd0);
    chk({tag, "_tkeep"}, 64'(tkeep_m), 64'd0);
    chk({tag, "_tlast"}, 64'(tlast_m), 64'd0);
    chk({tag, "_tuser"}, 64'(tuser_m), 64'd0);
    chk({tag, "_rvalid"}, 64'(rvalid_m), 64'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_ack = 0; n_done = 0;
    pid = 0; loaded = 1'b0; exp_tv = 1'b0;
    cur_size = 0; cur_n = 0; idx = 0;
    reset_i = 1'b1; avail = 1'b0; tready = 1'b0;
    sel = 1'b0; rsize = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk_reset_state("rst32");
    sel = 1'b1;
    #1 chk_reset_state("rst64");
    sel = 1'b0;

    tready_pct = 100; gap_pct = 0;
    sizes_q = '{9, 8};
    run(100);

    tready_pct = 60; gap_pct = 30;
    for (int i = 0; i < 25; i++) sizes_q.push_back($urandom_range(1, 300));
    run(6000);

    set_sel(1'b1);
    tready_pct = 100; gap_pct = 0;
    sizes_q = '{13, 1};
    run(100);
    tready_pct = 70; gap_pct = 20;
    for (int i = 0; i < 20; i++) sizes_q.push_back($urandom_range(1, 400));
    sizes_q.push_back(0);
    run(8000);

    set_sel(1'b0);
    tready_pct = 100; gap_pct = 0;
    sizes_q = '{200};
    repeat (20) step();
    do_reset();
    sizes_q.push_back(0);
    sizes_q.push_back(5);
    run(3000);

    tready_pct = 50; gap_pct = 0;
    sizes_q = '{0};
    run(4000);

    chk("ack_count", 64'(n_ack), 64'(n_done));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ethernet_tx_read_sequencer.md
# ethernet_tx_read_sequencer

Read-side sequencer of the Ethernet TX path. It sits between the two-slot TX packet buffer (synchronous-read RAM) and the AXI-Stream MAC interface. It walks a word pointer through the current packet and issues one buffer read per cycle. It registers `tvalid`, `tkeep`, `tlast` and `tuser` so they line up with the read data, which arrives one cycle later. On the final read of a packet it acknowledges the packet to the buffer.

## Interface
Parameters
- `data_width_p`, default 32: beat width in bits; only 32 and 64 are legal (simulation assertion otherwise).
- `eth_mtu_p`, default 2048: maximum packet size in bytes (power of two).
- Derived: `bytes_lp = data_width_p/8`; `addr_width_lp = $clog2(eth_mtu_p)`; `size_width_lp = $clog2(eth_mtu_p+1)`; `ptr_width_lp = $clog2(eth_mtu_p/bytes_lp)`.

Ports
- Clocking: one clock; reset is synchronous and active-high.
- `clk_i` in, 1: clock.
- `reset_i` in, 1: synchronous active-high reset.
- `packet_avail_i` in, 1: buffer holds a complete packet.
- `packet_rsize_i` in, `size_width_lp`: byte size of the current packet.
- `packet_rdata_i` in, `data_width_p`: buffer read data, valid the cycle after a read.
- `packet_rvalid_o` out, 1: buffer read enable.
- `packet_raddr_o` out, `addr_width_lp`: byte address of the read.
- `packet_ack_o` out, 1: releases the current packet slot.
- `send_complete_o` out, 1: one-cycle pulse per packet, equal to `packet_ack_o`.
- `tx_axis_tdata_o` out, `data_width_p`: wired directly from `packet_rdata_i`.
- `tx_axis_tkeep_o` out, `bytes_lp`: byte-valid mask for the beat.
- `tx_axis_tvalid_o` out, 1: beat valid.
- `tx_axis_tlast_o` out, 1: last beat of the packet.
- `tx_axis_tuser_o` out, 1: sideband user bit.
- `tx_axis_tready_i` in, 1: sink ready.

## Operation
- `sending = ~(tx_axis_tvalid_o & ~tx_axis_tready_i)`. This is true when the output stage is empty or is being drained this cycle.
- `ptr_end = ((packet_rsize_i - 1) >> log2(bytes_lp))`, truncated to `ptr_width_lp`.
- `last = (ptr == ptr_end)`.
- Read issue: when `packet_avail_i & sending`, assert `packet_rvalid_o` with `packet_raddr_o = ptr*bytes_lp`.
  - If not `last`, the pointer increments.
  - If `last`, the pointer clears to 0, and `packet_ack_o` and `send_complete_o` pulse in the same cycle.
- Pointer counter:
  - Counts 0..`eth_mtu_p/bytes_lp-1`; increment at the maximum wraps to 0.
  - Clear and up asserted together loads 1. This never occurs internally, but the counter primitive must implement it.
- Valid register: `tvalid <= rvalid_issue | (tvalid & ~tready)`. Set wins over clear.
- Sideband register:
  - Loads `{tkeep, tlast, tuser}` only when a read is issued; otherwise it holds.
  - `tlast = last`; `tuser = 0`.
  - `tkeep`: all ones when not `last`. On `last`, with `r = packet_rsize_i[log2(bytes_lp)-1:0]`: `r == 0` gives all ones, otherwise the low `r` bits are set.
- `packet_rsize_i == 0` is not a legal packet. It is treated as `ptr_end` = maximum index, so the packet sends `eth_mtu_p/bytes_lp` full beats.

## Timing
- Reset values: pointer 0, `tvalid` 0, `tkeep` 0, `tlast` 0, `tuser` 0.
- Read issued in cycle N; the beat is presented with `tvalid`/sideband/`tdata` in N+1.
- Back-to-back beats give a throughput of 1 beat/cycle while `tready=1`.
- Back-pressure: while `tvalid & ~tready`, no reads are issued and `tdata`/sideband/`tvalid` hold stable.
- Packets chain with no bubble: the first read of the next packet can issue the cycle after the ack.
- Reset mid-packet: the pointer returns to 0 and `tvalid` drops next edge. The partial packet is abandoned with no ack.

## Structure
- Parameter derivations (`bytes_lp`, widths) belong in a small shared package used by the TX/RX Ethernet blocks.
- Three leaf primitives are instantiated:
  - `bsg_counter_clear_up`: pointer counter.
  - `bsg_dff_reset_en`: sideband register, width `bytes_lp+2`.
  - `bsg_dff_reset_set_clear`: `tvalid` register, width 1, set-over-clear.
- The `tkeep` decode is a natural sub-module, `eth_tkeep_decode`.

## Test plan
- 32-bit, `rsize=9`, `tready=1`:
  - Reads at addresses 0, 4, 8 in consecutive cycles; ack with the third read.
  - Beats follow one cycle later; third beat has `tlast=1`, `tkeep=0001`.
- 32-bit, `rsize=8`: two beats, last `tkeep=1111`; `send_complete_o` pulses exactly once.
- Back-pressure: drop `tready` for 3 cycles mid-packet.
  - No `packet_rvalid_o` during the stall; `tvalid`/`tdata`/`tkeep` are held.
  - Resumes with the next address; beat count is unchanged.
- 64-bit, `rsize=13`: addresses 0, 8; last `tkeep=0x1F`.
- 64-bit, `rsize=1`: single beat with `tlast=1`, `tkeep=0x01`.
- Reset mid-packet, then `rsize=0` (32-bit):
  - After reset, `tvalid=0` and the first address is 0.
  - The `rsize=0` packet sends 512 beats, last address 2044, `tkeep=1111`, and the pointer wraps to 0.
